// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader types, error codes and instruction-memory constants
package imem_loader_pkg;

    localparam int          IMEM_ADDR_W = 4;
    localparam logic [7:0]  LOADER_HDR  = 8'hA5;
    localparam logic [3:0]  OPC_HALT    = 4'b1111;
    localparam logic [7:0]  HALT_WORD   = {OPC_HALT, 4'b0000};

    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_LEN     = 2'b01;
    localparam logic [1:0]  ERR_CSUM    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        FILL,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream, imem write port and CPU control of the loader
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_done;
    logic              load_error;
    logic [1:0]        err_code;

    // master = host / system side, slave = the loader itself
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_busy, load_done, load_error, err_code
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_busy, load_done, load_error, err_code
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frames a host byte stream into instruction memory, pads with HALT, releases CPU
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = IMEM_ADDR_W,
    parameter logic [7:0] HDR_BYTE  = LOADER_HDR,
    parameter logic [7:0] FILL_WORD = HALT_WORD
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    loader_state_t     state;
    loader_state_t     state_next;

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0]   len;
    logic [7:0]        sum;
    logic [1:0]        err;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        wdata_r;
    logic              done_r;

    logic              accept;
    logic              is_hdr;
    logic              len_ok;
    logic [ADDR_W:0]   len_m1;
    logic              last_data;
    logic              csum_ok;
    logic              fill_end;

    assign bus.in_ready = (state != FILL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_hdr       = (bus.in_data == HDR_BYTE);
    assign len_ok       = (bus.in_data != 8'd0) && (bus.in_data <= 8'(DEPTH));
    assign len_m1       = len - 1'b1;
    assign last_data    = ({1'b0, cnt} == len_m1);
    assign csum_ok      = ((sum + bus.in_data) == 8'd0);
    assign fill_end     = (cnt == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (accept && is_hdr) state_next = LEN;
            LEN:         if (accept) state_next = len_ok ? DATA : ERROR;
            DATA:        if (accept && last_data) state_next = CSUM;
            // len[ADDR_W] set means a full-depth image: nothing left to pad
            CSUM:        if (accept) state_next = !csum_ok ? ERROR : (len[ADDR_W] ? DONE : FILL);
            FILL:        if (fill_end) state_next = DONE;
            DONE, ERROR: if (accept && is_hdr) state_next = LEN;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            len     <= '0;
            sum     <= '0;
            err     <= ERR_NONE;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            done_r  <= 1'b0;
        end else begin
            we_r   <= 1'b0;
            done_r <= (state_next == DONE) && (state != DONE);
            case (state)
                LEN: if (accept) begin
                    len <= bus.in_data[ADDR_W:0];
                    cnt <= '0;
                    sum <= '0;
                    if (!len_ok) err <= ERR_LEN;
                end
                DATA: if (accept) begin
                    we_r    <= 1'b1;
                    addr_r  <= cnt;
                    wdata_r <= bus.in_data;
                    sum     <= sum + bus.in_data;
                    // hold at DEPTH-1 after a full image; otherwise cnt lands on N for FILL
                    if (!(last_data && len[ADDR_W])) cnt <= cnt + 1'b1;
                end
                CSUM: if (accept && !csum_ok) err <= ERR_CSUM;
                FILL: begin
                    we_r    <= 1'b1;
                    addr_r  <= cnt;
                    wdata_r <= FILL_WORD;
                    if (!fill_end) cnt <= cnt + 1'b1;
                end
                DONE, ERROR: if (accept && is_hdr) err <= ERR_NONE;
                default: ;
            endcase
        end
    end

    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign bus.cpu_hold   = (state != DONE);
    assign bus.load_busy  = (state == LEN) || (state == DATA) || (state == CSUM) || (state == FILL);
    assign bus.load_done  = done_r;
    assign bus.load_error = (state == ERROR);
    assign bus.err_code   = err;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Streams a program image into the CPU instruction memory over a byte valid/ready interface, replacing hierarchical preloading of instruction memory.
- Holds the CPU in reset while loading. Validates the frame length and checksum.
- Pads unused locations with a fill instruction, then releases the CPU.
- Sits beside cpu_top. It drives the instruction-memory write port and the CPU hold line.

Parameters:
- ADDR_W, 4, instruction-memory address width. DEPTH = 2**ADDR_W = 16 bytes.
- HDR_BYTE, 8'hA5, frame start marker.
- FILL_WORD, 8'b1111_00_00, written to locations N..DEPTH-1 (HALT).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  byte available from host
- in_ready  out  1  loader can accept a byte
- in_data  in  8  host byte
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  8  write data
- cpu_hold  out  1  keeps the CPU in reset while high
- load_busy  out  1  a frame is in progress (LEN, DATA, CSUM or FILL)
- load_done  out  1  one-cycle pulse on successful completion
- load_error  out  1  high while in ERROR
- err_code  out  2  01 = bad length, 10 = checksum mismatch, 00 otherwise

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_hold = 1, load_busy = 0, load_done = 0, load_error = 0, err_code = 00.
  - Reset mid-frame aborts immediately. Memory contents are left as-is and cpu_hold goes back to 1.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready is 1 in IDLE, LEN, DATA, CSUM, DONE and ERROR, and 0 in FILL.
  - in_data is ignored when there is no handshake.
- State machine:
  - IDLE: an accepted byte equal to HDR_BYTE goes to LEN. Any other byte is dropped.
  - LEN: the accepted byte is N.
    - N in 1..DEPTH: go to DATA, clear the running sum and the address counter, and set load_busy.
    - N = 0 or N > DEPTH: go to ERROR with err_code = 01.
  - DATA: each accepted byte b is written to address cnt.
    - The write is registered: imem_we = 1, imem_addr = cnt, imem_wdata = b in the cycle after the handshake.
    - sum <= sum + b, modulo 256. cnt increments.
    - After the Nth byte, go to CSUM.
  - CSUM: the accepted byte c is checked.
    - (sum + c) mod 256 == 0: go to FILL, or go straight to DONE if N == DEPTH.
    - Otherwise go to ERROR with err_code = 10.
  - FILL: one write per cycle of FILL_WORD to addresses N..DEPTH-1, with imem_we = 1 each cycle. After the write to DEPTH-1, go to DONE.
  - DONE:
    - On entry: load_done pulses for one cycle, cpu_hold drops to 0 in the same cycle, and load_busy = 0.
    - An accepted HDR_BYTE starts a reload: go to LEN with cpu_hold = 1 from the next cycle. Other bytes are dropped.
  - ERROR:
    - load_error = 1, cpu_hold = 1, load_busy = 0.
    - An accepted HDR_BYTE clears err_code and load_error and goes to LEN. Other bytes are dropped.
- General rules:
  - imem_we is never asserted outside the cycles listed above.
  - The address counter never exceeds DEPTH-1; there is no wrap.
  - A HDR_BYTE value arriving in LEN, DATA or CSUM is treated as ordinary data, not as a resync.
  - Checksum rule: the host sends c = (-sum(data)) mod 256.
  - Back-to-back valid bytes are accepted one per cycle with no bubbles, except during FILL.

Decomposition:
- Shared cpu package holds:
  - loader state enum: IDLE, LEN, DATA, CSUM, FILL, DONE, ERROR
  - ERR_NONE, ERR_LEN, ERR_CSUM
  - OPC_HALT = 4'b1111, from which FILL_WORD is built
  - IMEM_ADDR_W
- No sub-module is warranted: one FSM plus counter, sum and write registers.
- cpu_top gains a loader instance; its reset to the core becomes reset || cpu_hold.

Test Plan:
1. Nominal load: stream A5 04 B2 B5 14 F0 95 back-to-back, then let FILL complete.
   - mem[0..3] = B2, B5, 14, F0 and mem[4..15] = F0.
   - 12 FILL cycles with in_ready = 0.
   - load_done pulses once and cpu_hold falls in the same cycle.
   - Released CPU ends with R0 = 3, R1 = 1.
2. Bad checksum: stream A5 04 B2 B5 14 F0 96.
   - ERROR entered with err_code = 10 and load_error = 1.
   - cpu_hold stays 1 and no FILL writes occur.
   - Then resend stream 1: DONE reached and err_code = 00.
3. Bad length: stream A5 00, then separately A5 11.
   - ERROR with err_code = 01 each time and zero imem_we pulses.
4. Noise and backpressure:
   - Send 3C 00 before A5, with in_valid toggling every other cycle through the frame.
   - Noise bytes are dropped and memory matches scenario 1.
5. Full-depth frame: A5 10, 16 data bytes, valid checksum.
   - Goes CSUM→DONE with no FILL cycles and exactly 16 writes.
6. Reset mid-DATA: assert reset after the 2nd data byte.
   - Outputs return to reset values asynchronously (cpu_hold = 1, imem_we = 0).
   - The next full frame loads correctly.
